alu_seq: RTL

Sequencer directly upstream of the 4-bit combinational ALU. It accepts operation commands over a valid/ready channel, registers opcode and operands onto the ALU inputs, and captures the ALU result and flags into a result register. The result is presented downstream on a valid/ready channel. An optional chain mode feeds the previous result back as operand A, giving accumulator-style operation.

---
 rtl/alu_seq_pkg.sv | 23 ++
 rtl/alu_seq.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/alu_seq_pkg.sv
// Shared constants for the ALU sequencer: opcodes, FSM encoding and flag bit positions.
package alu_seq_pkg;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_NOT = 3'b010;
   localparam logic [2:0] OP_AND = 3'b011;
   localparam logic [2:0] OP_OR  = 3'b100;
   localparam logic [2:0] OP_XOR = 3'b101;
   localparam logic [2:0] OP_LT  = 3'b110;
   localparam logic [2:0] OP_EQ  = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_HOLD = 2'd2
   } state_e;

   localparam int FLG_Z = 2;
   localparam int FLG_O = 1;
   localparam int FLG_C = 0;

endpackage

// File: rtl/alu_seq.sv
// Command sequencer in front of an external 4-bit ALU with a registered result and accumulator chaining.
// Optional statistics outputs (stat_ops, stat_ovf) are built when ALU_SEQ_STATS_EN is defined.
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic [2:0]   cmd_op,
   input  logic [W-1:0] cmd_a,
   input  logic [W-1:0] cmd_b,
   input  logic         cmd_chain,
   output logic [2:0]   alu_f,
   output logic [W-1:0] alu_a,
   output logic [W-1:0] alu_b,
   input  logic [W-1:0] alu_out,
   input  logic         alu_zero,
   input  logic         alu_overflow,
   input  logic         alu_carry,
   output logic         res_valid,
   input  logic         res_ready,
   output logic [W-1:0] res_data,
   output logic [2:0]   res_flags
`ifdef ALU_SEQ_STATS_EN
   ,
   output logic [7:0]   stat_ops,
   output logic         stat_ovf
`endif
);

   // Both channels are valid/ready: a transfer happens in any cycle where valid
   // and ready are both high at the rising edge; valid never waits on ready.

   state_e        state_q, state_d;
   logic [2:0]    alu_f_q, alu_f_d;
   logic [W-1:0]  alu_a_q, alu_a_d;
   logic [W-1:0]  alu_b_q, alu_b_d;
   logic [W-1:0]  res_data_q, res_data_d;
   logic [2:0]    res_flags_q, res_flags_d;
   logic [W-1:0]  acc_q, acc_d;
   logic          accept;
   logic          retire;

   always_comb begin
      state_d     = state_q;
      alu_f_d     = alu_f_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      res_data_d  = res_data_q;
      res_flags_d = res_flags_q;
      acc_d       = acc_q;

      cmd_ready = (state_q == S_IDLE) | ((state_q == S_HOLD) & res_ready);
      accept    = cmd_valid & cmd_ready;
      retire    = (state_q == S_HOLD) & res_ready;

      // acc_q here is the pre-EXEC value, so a chain accepted on retirement sees the retired result.
      if (accept) begin
         alu_f_d = cmd_op;
         alu_b_d = cmd_b;
         alu_a_d = cmd_chain ? acc_q : cmd_a;
      end

      case (state_q)
         S_IDLE: begin
            if (accept) state_d = S_EXEC;
         end
         S_EXEC: begin
            res_data_d         = alu_out;
            res_flags_d[FLG_Z] = alu_zero;
            res_flags_d[FLG_O] = alu_overflow;
            res_flags_d[FLG_C] = alu_carry;
            acc_d              = alu_out;
            state_d            = S_HOLD;
         end
         S_HOLD: begin
            if (retire) state_d = accept ? S_EXEC : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         alu_f_q     <= '0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         res_data_q  <= '0;
         res_flags_q <= '0;
         acc_q       <= '0;
      end else begin
         state_q     <= state_d;
         alu_f_q     <= alu_f_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         res_data_q  <= res_data_d;
         res_flags_q <= res_flags_d;
         acc_q       <= acc_d;
      end
   end

   assign alu_f     = alu_f_q;
   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign res_valid = (state_q == S_HOLD);
   assign res_data  = res_data_q;
   assign res_flags = res_flags_q;

`ifdef ALU_SEQ_STATS_EN
   logic [7:0] stat_ops_q, stat_ops_d;
   logic       stat_ovf_q, stat_ovf_d;

   always_comb begin
      stat_ops_d = stat_ops_q;
      stat_ovf_d = stat_ovf_q;
      if (retire) begin
         stat_ops_d = stat_ops_q + 8'd1;
         stat_ovf_d = stat_ovf_q | res_flags_q[FLG_O];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_ops_q <= '0;
         stat_ovf_q <= 1'b0;
      end else begin
         stat_ops_q <= stat_ops_d;
         stat_ovf_q <= stat_ovf_d;
      end
   end

   assign stat_ops = stat_ops_q;
   assign stat_ovf = stat_ovf_q;
`endif

endmodule
